instr_fetch_queue: RTL and testbench

- Front-end stage directly upstream of decode in the dual-issue SPU.
- Fetches aligned instruction pairs (64 bits) from local-store instruction memory into a circular word queue.
- Presents the two oldest words to decode as instr1/instr2, honouring per-slot dependency stalls.
- On a taken branch from the odd pipe, flushes the queue, discards any in-flight fetch and redirects to BTA.

---
 rtl/instr_fetch_queue_pkg.sv | 21 ++
 rtl/instr_fetch_queue_if.sv | 28 ++
 rtl/instr_fetch_queue_fetch_ring.sv | 57 +++++
 rtl/instr_fetch_queue.sv | 86 ++++++++
 tb/tb_instr_fetch_queue.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths, types and the per-cycle issue-count rule for the instruction fetch queue.
package instr_fetch_queue_pkg;

  localparam int          WORD              = 32;
  localparam int          DOUBLEWORD        = 64;
  localparam int          LS_ADDR_WIDTH_DEF = 15;
  localparam logic [31:0] RESET_PC_DEF      = 32'h0;

  typedef logic [WORD-1:0] word_t;
  // Number of words moved into or out of the queue in one cycle (0..2).
  typedef logic [1:0]      slot_cnt_t;

  // A slot-1 stall blocks both slots; a slot-2 stall lets slot 1 go alone.
  function automatic slot_cnt_t issue_count(input logic stall1, input logic stall2,
                                            input logic valid1, input logic valid2);
    if (stall1 || !valid1) return 2'd0;
    if (stall2 || !valid2) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side memory port plus decode-side issue port of the fetch queue.
interface instr_fetch_queue_if #(parameter int LS_ADDR_WIDTH = 15);
  import instr_fetch_queue_pkg::*;

  logic                     imem_req;
  logic [LS_ADDR_WIDTH-1:0] imem_addr;
  logic [DOUBLEWORD-1:0]    imem_rdata;
  logic                     branch_taken;
  logic [31:0]              BTA;
  logic                     dep_stall_instr1;
  logic                     dep_stall_instr2;
  word_t                    instr1;
  word_t                    instr2;
  logic                     instr1_valid;
  logic                     instr2_valid;
  logic [31:0]              PC;

  modport slave (
    input  imem_rdata, branch_taken, BTA, dep_stall_instr1, dep_stall_instr2,
    output imem_req, imem_addr, instr1, instr2, instr1_valid, instr2_valid, PC
  );

  modport master (
    output imem_rdata, branch_taken, BTA, dep_stall_instr1, dep_stall_instr2,
    input  imem_req, imem_addr, instr1, instr2, instr1_valid, instr2_valid, PC
  );

endinterface

// File: rtl/instr_fetch_queue_fetch_ring.sv
// Circular word buffer: up to two words written and two read per cycle, head/head+1 visible.
module fetch_ring
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  slot_cnt_t     push_n,
  input  word_t         wdata0,
  input  word_t         wdata1,
  input  slot_cnt_t     pop_n,
  output logic [CW-1:0] count,
  output word_t         head0,
  output word_t         head1
);

  localparam int PW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_n != 2'd0) mem[wr_ptr]          <= wdata0;
      if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // The request throttle upstream is what keeps these true.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    (int'(count) + int'(push_n) - int'(pop_n) <= DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
    (int'(pop_n) <= int'(count)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: pair fetch from local store, dual-slot issue to decode, branch redirect.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH         = 8,
  parameter int          LS_ADDR_WIDTH = LS_ADDR_WIDTH_DEF,
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_queue_if.slave bus
);

  localparam int               CW      = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0]    DEPTH_C = (CW+2)'(DEPTH);
  localparam logic [LS_ADDR_WIDTH-1:0] RST_ADDR = RESET_PC[LS_ADDR_WIDTH-1:0];

  logic [LS_ADDR_WIDTH-1:0] fetch_pc, pc_q;
  logic                     inflight, skip_first;
  logic [CW-1:0]            count;
  logic [CW+1:0]            demand;
  logic                     req, ret, branch, unused_bta;
  slot_cnt_t                push_n, pop_n;
  word_t                    head0, head1, wdata0, wdata1;

  assign branch = bus.branch_taken;

  // Reserve room for the pair already in flight plus the one about to be requested.
  assign demand = {2'b00, count} + {{CW{1'b0}}, inflight, 1'b0} + (CW+2)'(2);
  assign req    = !reset && !branch && (demand <= DEPTH_C);

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;

  // A branch in the return cycle drops the pair; after a mid-pair target the low word is skipped.
  assign ret    = inflight && !branch;
  assign push_n = !ret ? 2'd0 : (skip_first ? 2'd1 : 2'd2);
  assign wdata0 = skip_first ? bus.imem_rdata[63:32] : bus.imem_rdata[31:0];
  assign wdata1 = bus.imem_rdata[63:32];

  assign pop_n = branch ? 2'd0
               : issue_count(bus.dep_stall_instr1, bus.dep_stall_instr2,
                             count != '0, count >= CW'(2));

  fetch_ring #(.DEPTH(DEPTH), .CW(CW)) u_ring (
    .clk    (clk),
    .reset  (reset),
    .flush  (branch),
    .push_n (push_n),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .pop_n  (pop_n),
    .count  (count),
    .head0  (head0),
    .head1  (head1)
  );

  assign bus.instr1_valid = count != '0;
  assign bus.instr2_valid = count >= CW'(2);
  assign bus.instr1       = bus.instr1_valid ? head0 : '0;
  assign bus.instr2       = bus.instr2_valid ? head1 : '0;
  assign bus.PC           = {{(32-LS_ADDR_WIDTH){1'b0}}, pc_q};

  // Only the local-store address bits of the target matter.
  assign unused_bta = ^bus.BTA[31:LS_ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RST_ADDR;
      pc_q       <= RST_ADDR;
      inflight   <= 1'b0;
      skip_first <= 1'b0;
    end else if (branch) begin
      fetch_pc   <= {bus.BTA[LS_ADDR_WIDTH-1:3], 3'b000};
      skip_first <= bus.BTA[2];
      pc_q       <= bus.BTA[LS_ADDR_WIDTH-1:0];
      inflight   <= 1'b0;
    end else begin
      inflight <= req;
      if (req)      fetch_pc   <= fetch_pc + LS_ADDR_WIDTH'(8);
      if (inflight) skip_first <= 1'b0;
      pc_q <= pc_q + LS_ADDR_WIDTH'({pop_n, 2'b00});
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; local store returns word 0x1000+(addr/4) at every word address.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue_if #(.LS_ADDR_WIDTH(15)) bus ();

  instr_fetch_queue #(.DEPTH(8), .LS_ADDR_WIDTH(15), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pair(input logic [14:0] a);
    logic [31:0] w;
    w = 32'h1000 + 32'(a >> 2);
    return {w + 32'h1, w};
  endfunction

  // One-cycle memory; without a request it returns a poison pair.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? pair(bus.imem_addr) : 64'hDEAD0001_DEAD0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.branch_taken = 1'b0;
    bus.BTA = 32'h0;
    bus.dep_stall_instr1 = 1'b0;
    bus.dep_stall_instr2 = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.branch_taken = 1'b0;
    bus.BTA = 32'h0;
    bus.dep_stall_instr1 = 1'b0;
    bus.dep_stall_instr2 = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    checks++; if (bus.instr1_valid !== 1'b0 || bus.instr2_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", bus.instr1_valid, bus.instr2_valid); end
    checks++; if (bus.instr1 !== 32'h0 || bus.instr2 !== 32'h0) begin errors++; $display("FAIL rst_instr got %h %h exp 0 0", bus.instr1, bus.instr2); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.PC); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0) begin errors++; $display("FAIL rst_first_req got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h8) begin errors++; $display("FAIL stream_req1 got %b/%h exp 1/8", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.instr1_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", bus.instr1_valid); end
    step();
    checks++; if (bus.instr1 !== 32'h1000 || bus.instr2 !== 32'h1001 || bus.instr2_valid !== 1'b1) begin errors++; $display("FAIL stream_c2 got %h %h v%b exp 1000 1001 v1", bus.instr1, bus.instr2, bus.instr2_valid); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL stream_pc0 got %h exp 0", bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h1002 || bus.instr2 !== 32'h1003 || bus.PC !== 32'h8) begin errors++; $display("FAIL stream_c3 got %h %h pc %h exp 1002 1003 pc 8", bus.instr1, bus.instr2, bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h1004 || bus.instr2 !== 32'h1005 || bus.PC !== 32'h10) begin errors++; $display("FAIL stream_c4 got %h %h pc %h exp 1004 1005 pc 10", bus.instr1, bus.instr2, bus.PC); end
  endtask

  task automatic test_stall1_fill();
    do_reset();
    bus.dep_stall_instr1 = 1'b1;
    step(); step(); step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h18) begin errors++; $display("FAIL fill_req3 got %b/%h exp 1/18", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fill_throttle got %b exp 0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b0 || bus.instr1 !== 32'h1000 || bus.instr2 !== 32'h1001) begin errors++; $display("FAIL fill_full got %b %h %h exp 0 1000 1001", bus.imem_req, bus.instr1, bus.instr2); end
    bus.dep_stall_instr1 = 1'b0;
    step();
    checks++; if (bus.instr1 !== 32'h1002 || bus.PC !== 32'h8 || bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h20) begin errors++; $display("FAIL fill_rel1 got %h pc %h req %b/%h exp 1002 pc 8 req 1/20", bus.instr1, bus.PC, bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.instr1 !== 32'h1004 || bus.PC !== 32'h10) begin errors++; $display("FAIL fill_rel2 got %h pc %h exp 1004 pc 10", bus.instr1, bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h1006 || bus.instr2 !== 32'h1007 || bus.PC !== 32'h18) begin errors++; $display("FAIL fill_rel3 got %h %h pc %h exp 1006 1007 pc 18", bus.instr1, bus.instr2, bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h1008 || bus.instr2 !== 32'h1009 || bus.PC !== 32'h20) begin errors++; $display("FAIL fill_rel4 got %h %h pc %h exp 1008 1009 pc 20", bus.instr1, bus.instr2, bus.PC); end
  endtask

  task automatic test_stall2_partial();
    do_reset();
    step(); step();
    bus.dep_stall_instr2 = 1'b1;
    step();
    bus.dep_stall_instr2 = 1'b0;
    #1;
    checks++; if (bus.instr1 !== 32'h1001 || bus.instr2 !== 32'h1002 || bus.PC !== 32'h4) begin errors++; $display("FAIL partial_shift got %h %h pc %h exp 1001 1002 pc 4", bus.instr1, bus.instr2, bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h1003 || bus.instr2 !== 32'h1004 || bus.PC !== 32'hC) begin errors++; $display("FAIL partial_next got %h %h pc %h exp 1003 1004 pc c", bus.instr1, bus.instr2, bus.PC); end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    bus.branch_taken = 1'b1;
    bus.BTA = 32'h0000_0124;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_no_req got %b exp 0", bus.imem_req); end
    step();
    bus.branch_taken = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h120 || bus.instr1_valid !== 1'b0) begin errors++; $display("FAIL br_b1 got %b/%h v%b exp 1/120 v0", bus.imem_req, bus.imem_addr, bus.instr1_valid); end
    step();
    checks++; if (bus.instr1_valid !== 1'b0 || bus.instr1 !== 32'h0) begin errors++; $display("FAIL br_b2_drop got v%b %h exp v0 0", bus.instr1_valid, bus.instr1); end
    step();
    checks++; if (bus.instr1 !== 32'h1049 || bus.instr2_valid !== 1'b0 || bus.instr2 !== 32'h0) begin errors++; $display("FAIL br_b3 got %h v2%b %h exp 1049 v20 0", bus.instr1, bus.instr2_valid, bus.instr2); end
    checks++; if (bus.PC !== 32'h124) begin errors++; $display("FAIL br_pc got %h exp 124", bus.PC); end
    step();
    checks++; if (bus.instr1 !== 32'h104A || bus.instr2 !== 32'h104B || bus.PC !== 32'h128) begin errors++; $display("FAIL br_b4 got %h %h pc %h exp 104a 104b pc 128", bus.instr1, bus.instr2, bus.PC); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(); step();
    bus.branch_taken = 1'b1;
    bus.BTA = 32'h40;
    step();
    bus.BTA = 32'h80;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_req got %b exp 0", bus.imem_req); end
    step();
    bus.branch_taken = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h80 || bus.instr1_valid !== 1'b0) begin errors++; $display("FAIL b2b_req got %b/%h v%b exp 1/80 v0", bus.imem_req, bus.imem_addr, bus.instr1_valid); end
    step();
    checks++; if (bus.instr1_valid !== 1'b0 || bus.imem_addr !== 15'h88) begin errors++; $display("FAIL b2b_wait got v%b %h exp v0 88", bus.instr1_valid, bus.imem_addr); end
    step();
    checks++; if (bus.instr1 !== 32'h1020 || bus.instr2 !== 32'h1021 || bus.PC !== 32'h80) begin errors++; $display("FAIL b2b_data got %h %h pc %h exp 1020 1021 pc 80", bus.instr1, bus.instr2, bus.PC); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    step(); step();
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr1_valid !== 1'b0 || bus.instr1 !== 32'h0) begin errors++; $display("FAIL rmid_outs got %b v%b %h exp 0 v0 0", bus.imem_req, bus.instr1_valid, bus.instr1); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h exp 0", bus.PC); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0) begin errors++; $display("FAIL rmid_restart got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.instr1_valid !== 1'b0 || bus.imem_addr !== 15'h8) begin errors++; $display("FAIL rmid_stale got v%b %h exp v0 8", bus.instr1_valid, bus.imem_addr); end
    step();
    checks++; if (bus.instr1 !== 32'h1000 || bus.instr2 !== 32'h1001 || bus.PC !== 32'h0) begin errors++; $display("FAIL rmid_data got %h %h pc %h exp 1000 1001 pc 0", bus.instr1, bus.instr2, bus.PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall1_fill();
    test_stall2_partial();
    test_branch();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
